// File: rtl/hit_readout_pkg.sv
// hit_readout_pkg: shared state encoding, default header tag and frame word types for hit_readout.
package hit_readout_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_TRAILER,
        S_DONE
    } state_t;

    localparam logic [6:0] HDR_TAG_DEF = 7'h55;

    typedef enum logic [1:0] {
        W_HDR,
        W_DATA,
        W_TRL
    } word_t;

endpackage

// File: rtl/hit_out_reg.sv
// hit_out_reg: stream holding register; load captures a word and raises valid, a handshake drops valid.
// Ports: clk, rst_n (async, active low), load/din (new word), ready (downstream accept),
//        data/valid (registered stream word).
module hit_out_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic          valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hit_readout.sv
// hit_readout: reads nhit words from the hit RAM and streams header + data (+ optional checksum trailer).
// Ports: clk, rst_n (async, active low); start/nhit begin a frame; rd_en/rd_addr/rd_data RAM read port
//        (1-cycle read latency); out_data/out_valid/out_ready word stream; busy, done (1-cycle pulse).
// Option: define HIT_READOUT_CKSUM_EN to append ~(sum of header and data words mod 2^DW) as a trailer.
module hit_readout
    import hit_readout_pkg::*;
#(
    parameter int                DW      = 16,
    parameter int                AW      = 9,
    parameter logic [DW-AW-1:0]  HDR_TAG = HDR_TAG_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] nhit,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

`ifdef HIT_READOUT_CKSUM_EN
    localparam state_t END_ST = S_TRAILER;
`else
    localparam state_t END_ST = S_DONE;
`endif

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] idx;
    logic          fire;
    logic          last;
    logic          load;
    logic [DW-1:0] load_data;
    logic [DW-1:0] trailer;
    word_t         wsel;

    assign fire = out_valid && out_ready;
    assign last = (idx + 1'b1) == cnt;

`ifdef HIT_READOUT_CKSUM_EN
    logic [DW-1:0] sum;
    // The trailer covers the word completing its handshake right now, so fold it in here.
    assign trailer = ~(sum + out_data);
`else
    assign trailer = '0;
`endif

    // The trailer is loaded in the same cycle the last word handshakes, so valid stays high across it.
    always_comb begin
        wsel = state == S_IDLE ? W_HDR : state == S_WAIT ? W_DATA : W_TRL;
        load = (state == S_IDLE && start) || state == S_WAIT;
`ifdef HIT_READOUT_CKSUM_EN
        load = load || (fire && ((state == S_HEADER && cnt == '0) || (state == S_SEND && last)));
`endif
        load_data = wsel == W_HDR ? {HDR_TAG, nhit} : wsel == W_DATA ? rd_data : trailer;
    end

    hit_out_reg #(.DW(DW)) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .din   (load_data),
        .ready (out_ready),
        .data  (out_data),
        .valid (out_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef HIT_READOUT_CKSUM_EN
            sum     <= '0;
`endif
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    cnt   <= nhit;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= S_HEADER;
`ifdef HIT_READOUT_CKSUM_EN
                    sum   <= '0;
`endif
                end
                S_HEADER: if (fire) begin
`ifdef HIT_READOUT_CKSUM_EN
                    sum <= sum + out_data;
`endif
                    if (cnt == '0) begin
                        state <= END_ST;
                        done  <= END_ST == S_DONE;
                        busy  <= END_ST != S_DONE;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= idx;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT:  state <= S_SEND;
                S_SEND: if (fire) begin
`ifdef HIT_READOUT_CKSUM_EN
                    sum <= sum + out_data;
`endif
                    idx <= idx + 1'b1;
                    if (last) begin
                        state <= END_ST;
                        done  <= END_ST == S_DONE;
                        busy  <= END_ST != S_DONE;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= idx + 1'b1;
                        state   <= S_FETCH;
                    end
                end
`ifdef HIT_READOUT_CKSUM_EN
                S_TRAILER: if (fire) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_readout.sv
// tb_hit_readout: randomized and directed frame checks of hit_readout against a frame-level reference model.
module tb_hit_readout;

    localparam int DW = 16;
    localparam int AW = 9;
`ifdef HIT_READOUT_CKSUM_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] nhit = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [512];
    logic [DW-1:0] words [$];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addrs [$];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt;
    int            stab_err;
    int            done_cyc;
    bit            timeout;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    hit_readout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nhit      (nhit),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_frame(input logic [AW-1:0] n, input int mode, input int extra_at, input int budget);
        logic          stalled;
        logic [DW-1:0] held;
        int            tail;
        words.delete();
        addrs.delete();
        done_cnt = 0;
        stab_err = 0;
        done_cyc = -1;
        timeout  = 1;
        stalled  = 0;
        held     = '0;
        tail     = -1;
        @(negedge clk);
        nhit  = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hdr_latency", {30'd0, busy, out_valid}, 32'd3);
        for (int c = 0; c < budget && tail != 0; c++) begin
            out_ready = pick(mode, c);
            start = (c == extra_at);
            if (c == extra_at) nhit = 9'd5;
            #1;
            if (stalled && !(out_valid === 1'b1 && out_data === held)) stab_err++;
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (out_valid && out_ready) words.push_back(out_data);
            if (rd_en) addrs.push_back(rd_addr);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    timeout  = 0;
                    tail     = 3;
                end
            end
            if (tail > 0) tail--;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [AW-1:0] n, input int mode);
        logic [DW-1:0] s;
        int            bad;
        int            m;
        exp_q.delete();
        s = {7'h55, n};
        exp_q.push_back(s);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[i]);
            s = s + mem[i];
        end
        if (TRL == 1) exp_q.push_back(~s);
        chk({tag, "/timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, "/len"}, words.size(), exp_q.size());
        m = words.size() < exp_q.size() ? words.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s/w%0d", tag, i), {16'd0, words[i]}, {16'd0, exp_q[i]});
        bad = 0;
        for (int i = 0; i < addrs.size(); i++) if (addrs[i] !== AW'(i)) bad++;
        chk({tag, "/rd_count"}, addrs.size(), {23'd0, n});
        chk({tag, "/addr_order"}, bad, 0);
        chk({tag, "/done_pulses"}, done_cnt, 1);
        chk({tag, "/stable"}, stab_err, 0);
        chk({tag, "/idle_after"}, {29'd0, busy, done, out_valid}, 32'd0);
        if (mode == 0) chk({tag, "/cycles"}, done_cyc, 1 + 3 * int'(n) + TRL);
    endtask

    initial begin
        int acc;
        bit hit;
        for (int i = 0; i < 512; i++) mem[i] = DW'($urandom);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {3'd0, out_valid, out_data, rd_en, rd_addr, busy, done}, 32'd0);
        rst_n = 1'b1;

        mem[0] = 16'h0101;
        mem[1] = 16'h0202;
        mem[2] = 16'h0303;
        run_frame(9'd3, 0, -1, 100);
        check_frame("t1", 9'd3, 0);
        chk("t1_header", {16'd0, words[0]}, 32'hAA03);
        if (TRL == 1) chk("t1_trailer", {16'd0, words[4]}, 32'h4FF6);

        run_frame(9'd0, 0, -1, 100);
        check_frame("t2", 9'd0, 0);
        chk("t2_header", {16'd0, words[0]}, 32'hAA00);
        if (TRL == 1) chk("t2_trailer", {16'd0, words[1]}, 32'h55FF);

        mem[0] = DW'($urandom);
        mem[1] = DW'($urandom);
        run_frame(9'd2, 1, -1, 200);
        check_frame("t3", 9'd2, 1);

        run_frame(9'd2, 0, 3, 100);
        check_frame("t4", 9'd2, 0);

        @(negedge clk);
        nhit      = 9'd3;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = 0;
        hit   = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (acc == 2 && out_valid) begin
                hit = 1;
                break;
            end
            if (out_valid && out_ready) acc++;
            @(negedge clk);
        end
        chk("t5_reach_word1", {31'd0, hit}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", {3'd0, out_valid, out_data, rd_en, rd_addr, busy, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_held_reset", {3'd0, out_valid, out_data, rd_en, rd_addr, busy, done}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        run_frame(9'd3, 0, -1, 100);
        check_frame("t5", 9'd3, 0);

        for (int i = 0; i < 512; i++) mem[i] = DW'($urandom);
        run_frame(9'd511, 2, -1, 8000);
        check_frame("t6", 9'd511, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
